dmem_resp: RTL and testbench

- Data-memory responder for the single-cycle core. It is the target end of the control unit's memory request lines (memRead_ctrl, write_ctrl_dataMem).
- Holds a word-organised data RAM and services loads and stores with a programmable number of wait states.
- Drives a combinational stall back to the core while a request is outstanding. Flags misaligned, out-of-range and illegal requests.

---
 rtl/dmem_resp.sv | 181 ++++++++++++++++++
 tb/tb_dmem_resp.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder: word-organised RAM serving core loads and stores
// after a programmable number of wait states, with error flagging.
module dmem_resp #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead_ctrl,
  input  logic        write_ctrl_dataMem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          write_q, write_d;
  logic          errFlag_q, errFlag_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req, reqErr, legalF3, misaligned;
  logic [AW+1:0] opAddr;
  logic [31:0]   opWdata;
  logic [2:0]    opFunct3;
  logic          opWrite;
  logic [AW-1:0] wordIdx;
  logic [4:0]    laneShift;
  logic [31:0]   oldWord, newWord, laneMask, loadVal;
  logic [7:0]    laneByte;
  logic [15:0]   laneHalf;
  logic          doAccess, memWe;

  assign req = memRead_ctrl | write_ctrl_dataMem;

  always_comb begin
    legalF3    = 1'b1;
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = addr[0];
      3'b010:         misaligned = |addr[1:0];
      default:        legalF3    = 1'b0;
    endcase
    reqErr = (memRead_ctrl & write_ctrl_dataMem) | ({1'b0, addr} >= BYTE_LIMIT)
           | misaligned | ~legalF3;
  end

  // With zero wait states the access happens on the capture edge, so the
  // live inputs feed the RAM port directly; otherwise the captured copies do.
  always_comb begin
    if (state_q == IDLE) begin
      opAddr   = addr[AW+1:0];
      opWdata  = wdata;
      opFunct3 = funct3;
      opWrite  = write_ctrl_dataMem;
    end else begin
      opAddr   = addr_q;
      opWdata  = wdata_q;
      opFunct3 = funct3_q;
      opWrite  = write_q;
    end
  end

  assign wordIdx   = opAddr[AW+1:2];
  assign laneShift = {opAddr[1:0], 3'b000};
  assign oldWord   = mem_q[wordIdx];
  assign laneByte  = oldWord[laneShift +: 8];
  assign laneHalf  = oldWord[{opAddr[1], 4'b0000} +: 16];

  always_comb begin
    case (opFunct3[1:0])
      2'b00: begin
        loadVal  = opFunct3[2] ? {24'b0, laneByte} : {{24{laneByte[7]}}, laneByte};
        laneMask = 32'h0000_00FF << laneShift;
      end
      2'b01: begin
        loadVal  = opFunct3[2] ? {16'b0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
        laneMask = 32'h0000_FFFF << laneShift;
      end
      default: begin
        loadVal  = oldWord;
        laneMask = 32'hFFFF_FFFF;
      end
    endcase
    newWord = (oldWord & ~laneMask) | ((opWdata << laneShift) & laneMask);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    write_d   = write_q;
    errFlag_d = errFlag_q;
    rdata_d   = rdata_q;
    doAccess  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d    = addr[AW+1:0];
          wdata_d   = wdata;
          funct3_d  = funct3;
          write_d   = write_ctrl_dataMem;
          errFlag_d = reqErr;
          if (reqErr) begin
            rdata_d = '0;
            state_d = RESP;
          end else if (WAIT_CYCLES == 0) begin
            doAccess = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          doAccess = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (doAccess && !opWrite) rdata_d = loadVal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      write_q   <= 1'b0;
      errFlag_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      write_q   <= write_d;
      errFlag_q <= errFlag_d;
      rdata_q   <= rdata_d;
    end
  end

  // RAM has no reset; the rst_n gate keeps a store from landing during reset.
  assign memWe = doAccess & opWrite & rst_n;

  always_ff @(posedge clk) begin
    if (memWe) mem_q[wordIdx] <= newWord;
  end

  assign rdata = rdata_q;
  assign stall = ((state_q == IDLE) & req) | (state_q == WAIT);
  assign done  = (state_q == RESP);
  assign err   = (state_q == RESP) & errFlag_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: a WAIT_CYCLES=2 instance (A) and a
// WAIT_CYCLES=0 instance (B), checked against a byte-array reference model.
module tb_dmem_resp;

  typedef struct {
    int          sel;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic        chk;
    logic [31:0] want;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdA = 1'b0, wrA = 1'b0, rdB = 1'b0, wrB = 1'b0;
  logic [31:0] addrIn = '0, wdataIn = '0;
  logic [2:0]  funct3In = '0;
  logic [31:0] rdataA, rdataB;
  logic        stallA, doneA, errA, stallB, doneB, errB;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [7:0]  refMem [2][1024];
  logic [31:0] refRd [2];

  dmem_resp #(.DEPTH(256), .WAIT_CYCLES(2)) dutA (
    .clk(clk), .rst_n(rst_n), .memRead_ctrl(rdA), .write_ctrl_dataMem(wrA),
    .addr(addrIn), .wdata(wdataIn), .funct3(funct3In),
    .rdata(rdataA), .stall(stallA), .done(doneA), .err(errA)
  );

  dmem_resp #(.DEPTH(256), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .rst_n(rst_n), .memRead_ctrl(rdB), .write_ctrl_dataMem(wrB),
    .addr(addrIn), .wdata(wdataIn), .funct3(funct3In),
    .rdata(rdataB), .stall(stallB), .done(doneB), .err(errB)
  );

  always #5 clk = ~clk;

  // Reference model: applies the request to a byte array and returns the
  // expected error flag and rdata.
  task automatic refTxn(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic e, output logic [31:0] r);
    int n, base;
    logic [31:0] val;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    e = (rd && wr) || (a >= 32'd1024) || !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
        || ((a % n) != 0);
    if (e) begin
      refRd[sel] = '0;
    end else begin
      base = int'(a[9:0]);
      if (wr) begin
        for (int i = 0; i < n; i++) refMem[sel][base + i] = wd[8*i +: 8];
      end else begin
        val = '0;
        for (int i = 0; i < n; i++) val = val | (32'(refMem[sel][base + i]) << (8 * i));
        if (!f3[2] && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
        refRd[sel] = val;
      end
    end
    r = refRd[sel];
  endtask

  // Drives one request and records what the DUT shows; judging is left to callers.
  task automatic runTxn(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output int lat, output logic stallOk, output logic errO,
                        output logic [31:0] rdO);
    logic st, dn, er;
    @(posedge clk); #1;
    addrIn = a; wdataIn = wd; funct3In = f3;
    if (sel == 0) begin rdA = rd; wrA = wr; end
    else          begin rdB = rd; wrB = wr; end
    lat = -1; stallOk = 1'b1; errO = 1'b0; rdO = 'x;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      st = (sel == 0) ? stallA : stallB;
      dn = (sel == 0) ? doneA  : doneB;
      er = (sel == 0) ? errA   : errB;
      if (dn === 1'b1) begin
        lat = c; stallOk = stallOk & (st === 1'b0); errO = er;
        rdO = (sel == 0) ? rdataA : rdataB;
      end else begin
        stallOk = stallOk & (st === 1'b1);
        if (er !== 1'b0) errO = 1'b1;
      end
    end
    rdA = 1'b0; wrA = 1'b0; rdB = 1'b0; wrB = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    testsRun += 2;
    if ({stallA, doneA, errA, stallB, doneB, errB} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset flags got %b want 000000", {stallA, doneA, errA, stallB, doneB, errB});
    end
    if ({rdataA, rdataB} !== 64'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset rdata got %h/%h want 0/0", rdataA, rdataB);
    end
    refRd[0] = '0; refRd[1] = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    txn_t tbl[$];
    int lat, eLat; logic sOk, eO, eE; logic [31:0] rO, eR;
    tbl.push_back('{0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 32'hDEADBEEF});
    foreach (tbl[i]) begin
      refTxn(tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, eE, eR);
      eLat = eE ? 1 : 3;
      runTxn(tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, lat, sOk, eO, rO);
      testsRun += 4;
      if (lat !== eLat) begin testsFailed++; $display("[TB] FAIL word[%0d] latency got %0d want %0d", i, lat, eLat); end
      if (sOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL word[%0d] stall shape got %b want 1", i, sOk); end
      if (eO !== eE) begin testsFailed++; $display("[TB] FAIL word[%0d] err got %b want %b", i, eO, eE); end
      if (rO !== eR) begin testsFailed++; $display("[TB] FAIL word[%0d] rdata got %h want %h", i, rO, eR); end
      if (tbl[i].chk) begin
        testsRun++;
        if (rO !== tbl[i].want) begin testsFailed++; $display("[TB] FAIL word[%0d] const got %h want %h", i, rO, tbl[i].want); end
      end
    end
  endtask

  task automatic test_byte_half();
    txn_t tbl[$];
    int lat, eLat; logic sOk, eO, eE; logic [31:0] rO, eR;
    tbl.push_back('{0, 1'b0, 1'b1, 32'h20, 32'h11223344, 3'b010, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h21, 32'hFFFFFF80, 3'b000, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b1, 32'h11228044});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h21, 32'h0, 3'b000, 1'b1, 32'hFFFFFF80});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h21, 32'h0, 3'b100, 1'b1, 32'h00000080});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h22, 32'h5555ABCD, 3'b001, 1'b0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h22, 32'h0, 3'b001, 1'b1, 32'hFFFFABCD});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h22, 32'h0, 3'b101, 1'b1, 32'h0000ABCD});
    foreach (tbl[i]) begin
      refTxn(tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, eE, eR);
      eLat = eE ? 1 : 3;
      runTxn(tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, lat, sOk, eO, rO);
      testsRun += 4;
      if (lat !== eLat) begin testsFailed++; $display("[TB] FAIL bytehalf[%0d] latency got %0d want %0d", i, lat, eLat); end
      if (sOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL bytehalf[%0d] stall shape got %b want 1", i, sOk); end
      if (eO !== eE) begin testsFailed++; $display("[TB] FAIL bytehalf[%0d] err got %b want %b", i, eO, eE); end
      if (rO !== eR) begin testsFailed++; $display("[TB] FAIL bytehalf[%0d] rdata got %h want %h", i, rO, eR); end
      if (tbl[i].chk) begin
        testsRun++;
        if (rO !== tbl[i].want) begin testsFailed++; $display("[TB] FAIL bytehalf[%0d] const got %h want %h", i, rO, tbl[i].want); end
      end
    end
  endtask

  task automatic test_errors();
    txn_t tbl[$];
    int lat, eLat; logic sOk, eO, eE; logic [31:0] rO, eR;
    tbl.push_back('{0, 1'b1, 1'b0, 32'h102, 32'h0, 3'b010, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h01, 32'h0, 3'b001, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h400, 32'h77777777, 3'b010, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b1, 32'h10, 32'h12345678, 3'b010, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h10, 32'h12345678, 3'b011, 1'b1, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h7FF, 32'h0, 3'b000, 1'b1, 32'h0});
    foreach (tbl[i]) begin
      refTxn(tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, eE, eR);
      eLat = eE ? 1 : ((tbl[i].sel == 0) ? 3 : 1);
      runTxn(tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, lat, sOk, eO, rO);
      testsRun += 4;
      if (lat !== eLat) begin testsFailed++; $display("[TB] FAIL errors[%0d] latency got %0d want %0d", i, lat, eLat); end
      if (sOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL errors[%0d] stall shape got %b want 1", i, sOk); end
      if (eO !== eE) begin testsFailed++; $display("[TB] FAIL errors[%0d] err got %b want %b", i, eO, eE); end
      if (rO !== eR) begin testsFailed++; $display("[TB] FAIL errors[%0d] rdata got %h want %h", i, rO, eR); end
      if (tbl[i].chk) begin
        testsRun++;
        if (rO !== tbl[i].want) begin testsFailed++; $display("[TB] FAIL errors[%0d] const got %h want %h", i, rO, tbl[i].want); end
      end
    end
  endtask

  task automatic test_back_to_back();
    txn_t tbl[$];
    int lat, eLat; logic sOk, eO, eE; logic [31:0] rO, eR;
    tbl.push_back('{1, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 3'b010, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 1'b1, 32'h0BADF00D});
    tbl.push_back('{1, 1'b0, 1'b1, 32'h43, 32'h000000A5, 3'b000, 1'b0, 32'h0});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 1'b1, 32'hA5ADF00D});
    foreach (tbl[i]) begin
      refTxn(tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, eE, eR);
      eLat = 1;
      runTxn(tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, lat, sOk, eO, rO);
      testsRun += 4;
      if (lat !== eLat) begin testsFailed++; $display("[TB] FAIL b2b[%0d] latency got %0d want %0d", i, lat, eLat); end
      if (sOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b[%0d] stall shape got %b want 1", i, sOk); end
      if (eO !== eE) begin testsFailed++; $display("[TB] FAIL b2b[%0d] err got %b want %b", i, eO, eE); end
      if (rO !== eR) begin testsFailed++; $display("[TB] FAIL b2b[%0d] rdata got %h want %h", i, rO, eR); end
      if (tbl[i].chk) begin
        testsRun++;
        if (rO !== tbl[i].want) begin testsFailed++; $display("[TB] FAIL b2b[%0d] const got %h want %h", i, rO, tbl[i].want); end
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic sOk, eO, eE; logic [31:0] rO, eR;
    refTxn(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010, eE, eR);
    runTxn(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010, lat, sOk, eO, rO);
    testsRun++;
    if (lat !== 3) begin testsFailed++; $display("[TB] FAIL abort setup latency got %0d want 3", lat); end
    @(posedge clk); #1;
    addrIn = 32'h30; wdataIn = 32'h55; funct3In = 3'b010; wrA = 1'b1;
    @(negedge clk);
    testsRun++;
    if (stallA !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort stall got %b want 1", stallA); end
    @(posedge clk); #1;
    rst_n = 1'b0; wrA = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      testsRun += 2;
      if ({stallA, doneA, errA, stallB, doneB, errB} !== 6'b0) begin
        testsFailed++;
        $display("[TB] FAIL abort flags[%0d] got %b want 000000", c, {stallA, doneA, errA, stallB, doneB, errB});
      end
      if ({rdataA, rdataB} !== 64'h0) begin
        testsFailed++;
        $display("[TB] FAIL abort rdata[%0d] got %h/%h want 0/0", c, rdataA, rdataB);
      end
    end
    rst_n = 1'b1;
    refRd[0] = '0; refRd[1] = '0;
    refTxn(0, 1'b1, 1'b0, 32'h30, 32'h0, 3'b010, eE, eR);
    runTxn(0, 1'b1, 1'b0, 32'h30, 32'h0, 3'b010, lat, sOk, eO, rO);
    testsRun += 3;
    if (lat !== 3) begin testsFailed++; $display("[TB] FAIL abort reload latency got %0d want 3", lat); end
    if (rO !== eR) begin testsFailed++; $display("[TB] FAIL abort reload model got %h want %h", rO, eR); end
    if (rO !== 32'hCAFEF00D) begin testsFailed++; $display("[TB] FAIL abort reload got %h want cafef00d", rO); end
  endtask

  task automatic test_no_request();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      testsRun++;
      if ({stallA, doneA, errA, stallB, doneB, errB} !== 6'b0) begin
        testsFailed++;
        $display("[TB] FAIL idle[%0d] flags got %b want 000000", c, {stallA, doneA, errA, stallB, doneB, errB});
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] legal [5];
    logic [2:0] bad [3];
    int lat, eLat, sel, r;
    logic sOk, eO, eE, rd, wr;
    logic [31:0] rO, eR, a, wd;
    logic [2:0] f3;
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bad   = '{3'b011, 3'b110, 3'b111};
    // First 32 transactions fill words 0..15 of both RAMs so later loads are defined.
    for (int i = 0; i < 112; i++) begin
      if (i < 32) begin
        sel = i / 16; rd = 1'b0; wr = 1'b1; a = 32'((i % 16) * 4); wd = $urandom; f3 = 3'b010;
      end else begin
        sel = int'($urandom_range(0, 1));
        r = int'($urandom_range(0, 9));
        rd = (r < 5); wr = (r == 0) || (r >= 5);
        f3 = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : bad[$urandom_range(0, 2)];
        r = int'($urandom_range(0, 15));
        a = (r == 0) ? 32'h400 + $urandom_range(0, 255) : (r == 1) ? $urandom : $urandom_range(0, 63);
        wd = $urandom;
      end
      refTxn(sel, rd, wr, a, wd, f3, eE, eR);
      eLat = eE ? 1 : ((sel == 0) ? 3 : 1);
      runTxn(sel, rd, wr, a, wd, f3, lat, sOk, eO, rO);
      testsRun += 4;
      if (lat !== eLat) begin testsFailed++; $display("[TB] FAIL rand[%0d] latency got %0d want %0d (a=%h f3=%b)", i, lat, eLat, a, f3); end
      if (sOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL rand[%0d] stall shape got %b want 1", i, sOk); end
      if (eO !== eE) begin testsFailed++; $display("[TB] FAIL rand[%0d] err got %b want %b (a=%h f3=%b)", i, eO, eE, a, f3); end
      if (rO !== eR) begin testsFailed++; $display("[TB] FAIL rand[%0d] rdata got %h want %h (a=%h f3=%b)", i, rO, eR, a, f3); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_no_request();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
